// File: rtl/axis_frame_out.sv
// axis_frame_out: buffers a no-backpressure sample stream in a FIFO
// and re-emits each frame as AXI4-Stream behind a magic/counter header.
module axis_frame_out #(
  parameter int          DEPTH = 1024,
  parameter logic [15:0] MAGIC = 16'hA55A
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              data_in,
  input  logic                     data_in_valid,
  input  logic                     data_in_last,
  input  logic                     ovf_clr,
  output logic [31:0]              m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic                     m_tlast,
  output logic                     m_tuser,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [15:0]              frame_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_DATA
  } state_t;

  state_t         state_q, state_d;
  logic [32:0]    mem_q [DEPTH];
  logic [AW-1:0]  wptr_q, wptr_d;
  logic [AW-1:0]  rptr_q, rptr_d;
  logic [LW-1:0]  level_q, level_d;
  logic           ovf_q, ovf_d;
  logic [15:0]    fcnt_q, fcnt_d;

  logic           full;
  logic           wr;
  logic           drop;
  logic           rd;
  logic           not_empty;
  logic [32:0]    head;

  // Full is judged on the registered level only, so a same-cycle pop
  // never makes room for an incoming word.
  assign full      = (level_q == LW'(DEPTH));
  assign wr        = data_in_valid && !full;
  assign drop      = data_in_valid && full;
  assign not_empty = (level_q != '0);
  assign head      = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (wr) begin
      mem_q[wptr_q] <= {data_in_last, data_in};
    end
  end

  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    rd       = 1'b0;
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tlast  = 1'b0;
    m_tuser  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (not_empty) begin
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        m_tvalid = 1'b1;
        m_tdata  = {MAGIC, fcnt_q};
        m_tuser  = 1'b1;
        if (m_tready) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (not_empty) begin
          m_tvalid = 1'b1;
          m_tdata  = head[31:0];
          m_tlast  = head[32];
          if (m_tready) begin
            rd = 1'b1;
            if (head[32]) begin
              fcnt_d  = fcnt_q + 16'd1;
              state_d = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wptr_d  = wr ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = rd ? rptr_q + AW'(1) : rptr_q;
    level_d = level_q;
    if (wr && !rd) begin
      level_d = level_q + LW'(1);
    end else if (rd && !wr) begin
      level_d = level_q - LW'(1);
    end
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign level     = level_q;
  assign overflow  = ovf_q;
  assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_axis_frame_out.sv
// tb_axis_frame_out: scoreboard bench for axis_frame_out,
// small FIFO so the full/overflow paths are reachable.
module tb_axis_frame_out;

  localparam int          DEPTH = 8;
  localparam logic [15:0] MAGIC = 16'hA55A;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_in = '0;
  logic        data_in_valid = 1'b0;
  logic        data_in_last = 1'b0;
  logic        ovf_clr = 1'b0;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tlast;
  logic        m_tuser;
  logic [3:0]  level;
  logic        overflow;
  logic [15:0] frame_cnt;

  axis_frame_out #(
    .DEPTH(DEPTH),
    .MAGIC(MAGIC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .data_in_valid(data_in_valid),
    .data_in_last (data_in_last),
    .ovf_clr      (ovf_clr),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tlast      (m_tlast),
    .m_tuser      (m_tuser),
    .level        (level),
    .overflow     (overflow),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [33:0] sb [$];
  logic [15:0] fc_model = '0;
  int          cyc = 0;
  int          last_cyc = -1;
  bit          chk_gap = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_hdr();
    sb.push_back({1'b1, 1'b0, MAGIC, fc_model});
    fc_model++;
  endtask

  task automatic send(input logic [31:0] d, input logic l, input bit exp);
    data_in       = d;
    data_in_valid = 1'b1;
    data_in_last  = l;
    if (exp) sb.push_back({1'b0, l, d});
    tick();
    data_in_valid = 1'b0;
    data_in_last  = 1'b0;
  endtask

  task automatic drain(input bit toggle);
    for (int i = 0; i < 400 && sb.size() != 0; i++) begin
      if (toggle) m_tready = ~m_tready;
      tick();
    end
    if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
    repeat (3) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    fc_model = '0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin : monitor
    logic [33:0] obs;
    logic [33:0] prev;
    logic [33:0] exp;
    bit          stall;
    stall = 1'b0;
    prev  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      obs = {m_tuser, m_tlast, m_tdata};
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("stable_valid", 64'(m_tvalid), 64'd1);
          check("stable_beat", 64'(obs), 64'(prev));
        end
        if (m_tvalid && m_tready) begin
          if (sb.size() == 0) begin
            check("extra_beat", 64'(obs), 64'h3_FFFF_FFFF);
          end else begin
            exp = sb.pop_front();
            check("beat", 64'(obs), 64'(exp));
            if (chk_gap && obs[33] && last_cyc >= 0)
              check("idle_gap", 64'(cyc - last_cyc), 64'd2);
            if (obs[32]) last_cyc = cyc;
          end
        end
        stall = m_tvalid && !m_tready;
        prev  = obs;
      end
    end
  end

  initial begin
    #2;
    tick();
    check("rst_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_tdata", 64'(m_tdata), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_fcnt", 64'(frame_cnt), 64'd0);
    rst = 1'b0;
    tick();

    // single frame, latency
    m_tready = 1'b1;
    push_hdr();
    send(32'h1, 1'b0, 1'b1);
    check("lat_level1", 64'(level), 64'd1);
    check("lat_novalid", 64'(m_tvalid), 64'd0);
    send(32'h2, 1'b0, 1'b1);
    check("lat_hdr_valid", 64'(m_tvalid), 64'd1);
    check("lat_hdr_user", 64'(m_tuser), 64'd1);
    check("lat_hdr_data", 64'(m_tdata), 64'hA55A0000);
    send(32'h3, 1'b0, 1'b1);
    send(32'h4, 1'b1, 1'b1);
    drain(1'b0);
    check("t1_fcnt", 64'(frame_cnt), 64'd1);
    check("t1_level", 64'(level), 64'd0);

    // 22-word frame under toggling ready
    push_hdr();
    for (int i = 0; i < 22; i++) begin
      m_tready = ~m_tready;
      send(32'h200 + 32'(i), i == 21, 1'b1);
      for (int k = 0; k < 2; k++) begin
        m_tready = ~m_tready;
        tick();
      end
    end
    drain(1'b1);
    m_tready = 1'b1;
    tick();
    check("t2_level", 64'(level), 64'd0);
    check("t2_ovf", 64'(overflow), 64'd0);
    check("t2_fcnt", 64'(frame_cnt), 64'd2);

    // overflow with ready low
    m_tready = 1'b0;
    push_hdr();
    for (int i = 0; i < 10; i++)
      send(32'h100 + 32'(i), i == 7, i < 8);
    check("t3_level", 64'(level), 64'd8);
    check("t3_ovf", 64'(overflow), 64'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t3_ovf_clr", 64'(overflow), 64'd0);
    m_tready = 1'b1;
    drain(1'b0);
    check("t3_level0", 64'(level), 64'd0);
    check("t3_fcnt", 64'(frame_cnt), 64'd3);

    // pop and push at full in the same cycle
    m_tready = 1'b0;
    push_hdr();
    for (int i = 0; i < 8; i++)
      send(32'h300 + 32'(i), i == 7, 1'b1);
    repeat (2) tick();
    check("t4_hdr_wait", 64'(m_tvalid), 64'd1);
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    tick();
    check("t4_full", 64'(level), 64'd8);
    m_tready = 1'b1;
    send(32'hDEAD, 1'b0, 1'b0);
    check("t4_level7", 64'(level), 64'd7);
    check("t4_ovf", 64'(overflow), 64'd1);
    drain(1'b0);
    check("t4_fcnt", 64'(frame_cnt), 64'd4);

    // back-to-back frames after reset
    do_reset();
    check("t5_rst_ovf", 64'(overflow), 64'd0);
    chk_gap  = 1'b1;
    last_cyc = -1;
    for (int f = 0; f < 2; f++) begin
      push_hdr();
      for (int i = 0; i < 3; i++)
        send(32'h500 + 32'(f * 16 + i), i == 2, 1'b1);
    end
    drain(1'b0);
    chk_gap = 1'b0;
    check("t5_fcnt", 64'(frame_cnt), 64'd2);

    // reset mid-frame
    push_hdr();
    for (int i = 0; i < 5; i++)
      send(32'h600 + 32'(i), i == 4, i < 2);
    check("t6_sb", 64'(sb.size()), 64'd0);
    rst = 1'b1;
    #1;
    check("t6_tvalid", 64'(m_tvalid), 64'd0);
    check("t6_tdata", 64'(m_tdata), 64'd0);
    check("t6_level", 64'(level), 64'd0);
    check("t6_fcnt", 64'(frame_cnt), 64'd0);
    sb.delete();
    fc_model = '0;
    tick();
    rst = 1'b0;
    tick();
    push_hdr();
    send(32'h700, 1'b0, 1'b1);
    send(32'h701, 1'b1, 1'b1);
    drain(1'b0);
    check("t6_fcnt1", 64'(frame_cnt), 64'd1);
    check("t6_level0", 64'(level), 64'd0);
    check("end_sb", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axis_frame_out.md
Name: axis_frame_out

Overview:
- Downstream consumer of the 22-channel processing stage's output stream (32-bit data, valid, last).
- That stream carries no backpressure, so this block buffers it in an internal FIFO.
- Re-emits each frame as an AXI4-Stream master towards the DMA/host link. Each frame is prefixed with a header word that carries a magic number and a rolling frame counter.
- Detects and flags input overflow.

Parameters:
- DEPTH, 1024, FIFO depth in 32-bit words; power of 2, ≥ 4.
- MAGIC, 16'hA55A, upper half of the header word.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- data_in  input  32  sample word from processing stage
- data_in_valid  input  1  data_in qualifier, one word per cycle, no backpressure
- data_in_last  input  1  marks final word of a frame (qualified by data_in_valid)
- ovf_clr  input  1  synchronous one-cycle clear of the overflow flag
- m_tdata  output  32  stream data
- m_tvalid  output  1  stream valid
- m_tready  input  1  stream ready
- m_tlast  output  1  last word of frame
- m_tuser  output  1  high on the header beat only
- level  output  $clog2(DEPTH)+1  current FIFO occupancy
- overflow  output  1  sticky: at least one input word was dropped
- frame_cnt  output  16  number of frames fully transmitted (wraps)

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While rst is high: all registers clear, FIFO empty, state=S_IDLE, level=0, overflow=0, frame_cnt=0. All outputs 0 (m_tvalid=0).
- FIFO entry: {last, data}, 33 bits. The read pointer provides first-word-fall-through.
- Write: occurs when data_in_valid=1 and registered level<DEPTH.
- Full: if data_in_valid=1 and level==DEPTH, the word (including its last bit) is dropped and overflow←1. This holds even when a read happens in the same cycle; the full decision uses the registered level only.
- overflow clears only on rst or ovf_clr. If ovf_clr and a new drop coincide, the drop wins (overflow stays 1).
- level update: +1 on write only, −1 on read only, unchanged on both or neither. Pointers wrap modulo DEPTH.
- Read FSM, registered state:
  - S_IDLE: m_tvalid=0. Next state is S_HDR if level≠0, else stay.
  - S_HDR: m_tvalid=1, m_tdata={MAGIC, frame_cnt}, m_tuser=1, m_tlast=0. Nothing is popped. On m_tvalid&m_tready → S_DATA.
  - S_DATA: m_tvalid=(level≠0), m_tdata=head data, m_tlast=head last, m_tuser=0. Handshake pops one entry. A handshake with head last=1 → frame_cnt+1 (wraps 16'hFFFF→0), → S_IDLE.
- m_tdata, m_tlast and m_tuser must not change while m_tvalid=1 and m_tready=0 (AXI stability). m_tvalid never drops in S_HDR without a handshake.
- Latency: first write of a frame at cycle t → level=1 at t+1 → S_HDR and m_tvalid=1 at t+2. With m_tready held high, the header transfers at t+2 and the first data word at t+3.
- Back-to-back frames: after the last beat, one S_IDLE cycle is inserted before the next header.
- Words written while the FSM sits in S_HDR/S_DATA are queued; no loss unless full.
- Dropped last word: the frame is not terminated. The following frame's words are emitted as a continuation of it, and overflow=1 signals corruption to software.
- Reset mid-frame: all state is discarded immediately; there is no partial-frame completion.

Test Plan:
- Single frame: 4 words 0x1..0x4, last on 0x4, m_tready=1 → beats 0xA55A0000 (tuser=1), 0x1, 0x2, 0x3, 0x4 (tlast=1). Header appears 2 cycles after the first write. frame_cnt=1 afterwards.
- Backpressure: 22-word frame with m_tready toggling 1/0 each cycle → all 23 beats in order, data stable while stalled. level returns to 0, overflow=0.
- Overflow, DEPTH=8, m_tready=0: 10 consecutive words → level=8, words 9 and 10 dropped, overflow=1. ovf_clr pulse → overflow=0, and with m_tready=1 the 8 stored words drain after the header.
- Simultaneous read/write at full, DEPTH=8: level=8, handshake and data_in_valid in the same cycle → input dropped, level=7, overflow=1.
- Back-to-back: two 3-word frames written contiguously, m_tready=1 → headers 0xA55A0000 then 0xA55A0001, with exactly one idle cycle between the first tlast and the second header.
- Reset mid-frame: assert rst after the header and 2 data beats of a 5-word frame → outputs 0 immediately, level=0, frame_cnt=0. A new 2-word frame afterwards gets header 0xA55A0000.
